// File: rtl/bsg_fifo_words_to_pkt_if.sv
// Word-in / packet-out handshake bundle for bsg_fifo_words_to_pkt.
// The slave modport is the assembler; the master modport is the FIFO side plus the packet consumer.
interface bsg_fifo_words_to_pkt_if #(
    parameter int word_width_p = 32,
    parameter int pkt_words_p  = 4
);
    // Strict valid/ready on both channels: a transfer happens on a rising clock edge
    // where valid and ready are both high. Once raised, pkt_v_o holds until that edge.
    logic                                 v_i;
    logic [word_width_p-1:0]              data_i;
    logic                                 ready_o;
    logic                                 pkt_v_o;
    logic [pkt_words_p*word_width_p-1:0]  pkt_o;
    logic                                 pkt_ready_i;

    modport slave (
        input  v_i,
        input  data_i,
        output ready_o,
        output pkt_v_o,
        output pkt_o,
        input  pkt_ready_i
    );

    modport master (
        output v_i,
        output data_i,
        input  ready_o,
        input  pkt_v_o,
        input  pkt_o,
        output pkt_ready_i
    );
endinterface

// File: rtl/bsg_fifo_words_to_pkt.sv
// Packs pkt_words_p consecutive FIFO words into one wide packet, first word in the LSBs.
// Optional partial-packet drop on idle: define BSG_FIFO_WORDS_TO_PKT_TIMEOUT_EN.
module bsg_fifo_words_to_pkt #(
    parameter int word_width_p     = 32,
    parameter int pkt_words_p      = 4,
    parameter int timeout_cycles_p = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    bsg_fifo_words_to_pkt_if.slave               io_if,
    output logic [$clog2(pkt_words_p+1)-1:0]     word_cnt_o,
    output logic [31:0]                          pkt_cnt_o,
    output logic                                 timeout_o,
    output logic                                 state_o
);
    localparam int cnt_w = $clog2(pkt_words_p + 1);

    typedef enum logic {
        E_COLLECT = 1'b0,
        E_SEND    = 1'b1
    } state_e;

    state_e                              state_q;
    logic [cnt_w-1:0]                    word_cnt_q;
    logic [cnt_w-1:0]                    word_cnt_d;
    logic [pkt_words_p*word_width_p-1:0] pkt_q;
    logic [31:0]                         pkt_cnt_q;
    logic [31:0]                         pkt_cnt_d;
    logic                                accept;

    assign accept     = io_if.v_i && (state_q == E_COLLECT);
    assign word_cnt_d = word_cnt_q + cnt_w'(1);
    assign pkt_cnt_d  = pkt_cnt_q + 32'd1;

`ifdef BSG_FIFO_WORDS_TO_PKT_TIMEOUT_EN
    localparam int idle_w = $clog2(timeout_cycles_p + 1);

    logic [idle_w-1:0] idle_q;
    logic              timeout_q;
    logic              idle_run;
    logic              timeout_hit;

    // Counts only while a partial packet is parked and nothing arrives this cycle.
    assign idle_run    = (state_q == E_COLLECT) && (word_cnt_q != '0) && !accept;
    assign timeout_hit = idle_run && (idle_q == idle_w'(timeout_cycles_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (!idle_run || timeout_hit) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + idle_w'(1);
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= E_COLLECT;
            word_cnt_q <= '0;
            pkt_q      <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            case (state_q)
                E_COLLECT: begin
                    if (accept) begin
                        // Upper slices keep stale data; every slot is rewritten before send.
                        for (int k = 0; k < pkt_words_p; k++) begin
                            if (word_cnt_q == cnt_w'(k)) begin
                                pkt_q[k*word_width_p +: word_width_p] <= io_if.data_i;
                            end
                        end
                        word_cnt_q <= word_cnt_d;
                        if (word_cnt_q == cnt_w'(pkt_words_p - 1)) begin
                            state_q <= E_SEND;
                        end
                    end
`ifdef BSG_FIFO_WORDS_TO_PKT_TIMEOUT_EN
                    else if (timeout_hit) begin
                        word_cnt_q <= '0;
                    end
`endif
                end
                E_SEND: begin
                    if (io_if.pkt_ready_i) begin
                        state_q    <= E_COLLECT;
                        word_cnt_q <= '0;
                        pkt_cnt_q  <= pkt_cnt_d;
                    end
                end
                default: state_q <= E_COLLECT;
            endcase
        end
    end

    assign io_if.ready_o = (state_q == E_COLLECT);
    assign io_if.pkt_v_o = (state_q == E_SEND);
    assign io_if.pkt_o   = pkt_q;
    assign word_cnt_o    = word_cnt_q;
    assign pkt_cnt_o     = pkt_cnt_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_bsg_fifo_words_to_pkt.sv
// Self-checking bench for bsg_fifo_words_to_pkt (4 x 32-bit words, timeout 8 when enabled).
// Table vectors, hand sequences for corners, then random traffic against a queue model.
module tb_bsg_fifo_words_to_pkt;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam int PW = W * N;

    logic        clk;
    logic        reset_n;
    logic [2:0]  word_cnt;
    logic [31:0] pkt_cnt;
    logic        timeout;
    logic        state;

    bsg_fifo_words_to_pkt_if #(.word_width_p(W), .pkt_words_p(N)) io ();

    bsg_fifo_words_to_pkt #(
        .word_width_p(W), .pkt_words_p(N), .timeout_cycles_p(TO)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .io_if(io),
        .word_cnt_o(word_cnt), .pkt_cnt_o(pkt_cnt), .timeout_o(timeout), .state_o(state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic prdy);
        io.v_i = v;
        io.data_i = d;
        io.pkt_ready_i = prdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        io.v_i = 1'b0;
        io.data_i = '0;
        io.pkt_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},   PW'(io.ready_o), PW'(1));
        check({tag, "_pkt_v"},   PW'(io.pkt_v_o), PW'(0));
        check({tag, "_word_cnt"}, PW'(word_cnt),  PW'(0));
        check({tag, "_pkt_cnt"},  PW'(pkt_cnt),   PW'(0));
        check({tag, "_pkt"},      io.pkt_o,       '0);
        check({tag, "_timeout"},  PW'(timeout),   PW'(0));
        check({tag, "_state"},    PW'(state),     PW'(0));
    endtask

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic          prdy;
        logic          e_ready;
        logic          e_pv;
        int            e_cnt;
        int            e_pcnt;
        logic          chk_pkt;
        logic [PW-1:0] e_pkt;
    } vec_t;

    vec_t tbl[13];

    // ---------------- random model state ----------------
    logic [W-1:0] m_words[$];
    bit           m_sending;
    int           m_pcnt;
    int           m_idle;
    bit           m_tpulse;

    function automatic logic [PW-1:0] pack_words();
        logic [PW-1:0] p = '0;
        for (int k = 0; k < m_words.size(); k++) p[k*W +: W] = m_words[k];
        return p;
    endfunction

    initial begin
        logic [PW-1:0] hold_pkt;
        int pulses;
        int pulse_at;

        reset_n = 1'b0;
        io.v_i = 1'b0;
        io.data_i = '0;
        io.pkt_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // ---------- back-to-back and gapped input, table driven ----------
        tbl[0]  = '{1'b1, 32'h11,   1'b1, 1'b1, 1'b0, 1, 0, 1'b0, '0};
        tbl[1]  = '{1'b1, 32'h22,   1'b1, 1'b1, 1'b0, 2, 0, 1'b0, '0};
        tbl[2]  = '{1'b1, 32'h33,   1'b1, 1'b1, 1'b0, 3, 0, 1'b0, '0};
        tbl[3]  = '{1'b1, 32'h44,   1'b1, 1'b0, 1'b1, 4, 0, 1'b1,
                    128'h00000044_00000033_00000022_00000011};
        tbl[4]  = '{1'b1, 32'h55,   1'b1, 1'b1, 1'b0, 0, 1, 1'b0, '0};
        tbl[5]  = '{1'b1, 32'hA1,   1'b1, 1'b1, 1'b0, 1, 1, 1'b0, '0};
        tbl[6]  = '{1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, 1, 1, 1'b0, '0};
        tbl[7]  = '{1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, 1, 1, 1'b0, '0};
        tbl[8]  = '{1'b1, 32'hA2,   1'b1, 1'b1, 1'b0, 2, 1, 1'b0, '0};
        tbl[9]  = '{1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, 2, 1, 1'b0, '0};
        tbl[10] = '{1'b1, 32'hA3,   1'b1, 1'b1, 1'b0, 3, 1, 1'b0, '0};
        tbl[11] = '{1'b1, 32'hA4,   1'b1, 1'b0, 1'b1, 4, 1, 1'b1,
                    128'h000000A4_000000A3_000000A2_000000A1};
        tbl[12] = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 0, 2, 1'b0, '0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].prdy);
            check($sformatf("tbl%0d_ready", i), PW'(io.ready_o), PW'(tbl[i].e_ready));
            check($sformatf("tbl%0d_pkt_v", i), PW'(io.pkt_v_o), PW'(tbl[i].e_pv));
            check($sformatf("tbl%0d_cnt", i),   PW'(word_cnt),   PW'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_pcnt", i),  PW'(pkt_cnt),    PW'(tbl[i].e_pcnt));
            if (tbl[i].chk_pkt) check($sformatf("tbl%0d_pkt", i), io.pkt_o, tbl[i].e_pkt);
        end

        // ---------- backpressure ----------
        for (int k = 0; k < N; k++) step(1'b1, 32'hB0 + k, 1'b0);
        hold_pkt = 128'h000000B3_000000B2_000000B1_000000B0;
        for (int c = 0; c < 10; c++) begin
            check("bp_ready_low", PW'(io.ready_o), PW'(0));
            check("bp_pkt_v_high", PW'(io.pkt_v_o), PW'(1));
            check("bp_pkt_stable", io.pkt_o, hold_pkt);
            step(1'b1, 32'hC0, 1'b0);
        end
        step(1'b1, 32'hC0, 1'b1);
        check("bp_release_pkt_v", PW'(io.pkt_v_o), PW'(0));
        check("bp_release_cnt", PW'(word_cnt), PW'(0));
        check("bp_release_pcnt", PW'(pkt_cnt), PW'(3));
        step(1'b1, 32'hC0, 1'b0);
        check("bp_next_word_cnt", PW'(word_cnt), PW'(1));

        // ---------- asynchronous reset mid-packet ----------
        step(1'b1, 32'hC1, 1'b0);
        check("mid_cnt_before_reset", PW'(word_cnt), PW'(2));
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) step(1'b1, 32'hD0 + k, 1'b0);
        check("post_reset_pkt_v", PW'(io.pkt_v_o), PW'(1));
        check("post_reset_pkt", io.pkt_o, 128'h000000D3_000000D2_000000D1_000000D0);
        step(1'b0, 32'h0, 1'b1);
        check("post_reset_pcnt", PW'(pkt_cnt), PW'(1));

        // ---------- randomized traffic vs. queue model ----------
        do_reset();
        m_words.delete();
        m_sending = 0;
        m_pcnt = 0;
        m_idle = 0;
        for (int c = 0; c < 600; c++) begin
            logic          rv;
            logic [W-1:0]  rd;
            logic          rp;
            rv = ($urandom_range(0, 99) < 70);
            rd = $urandom;
            rp = ($urandom_range(0, 99) < 50);
            io.v_i = rv;
            io.data_i = rd;
            io.pkt_ready_i = rp;
            // Scoreboard: a packet leaves on valid & ready.
            if (io.pkt_v_o && rp) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_pkt", PW'(1), PW'(0));
                end else begin
                    check("rnd_pkt", io.pkt_o, exp_q.pop_front());
                end
            end
            m_tpulse = 0;
            if (m_sending) begin
                if (rp) begin
                    m_sending = 0;
                    m_words.delete();
                    m_pcnt++;
                end
                m_idle = 0;
            end else if (rv) begin
                m_words.push_back(rd);
                m_idle = 0;
                if (m_words.size() == N) begin
                    m_sending = 1;
                    exp_q.push_back(pack_words());
                end
            end else if (m_words.size() > 0) begin
`ifdef BSG_FIFO_WORDS_TO_PKT_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO) begin
                    m_words.delete();
                    m_idle = 0;
                    m_tpulse = 1;
                end
`endif
            end else begin
                m_idle = 0;
            end
            @(posedge clk);
            @(negedge clk);
            check("rnd_pkt_v", PW'(io.pkt_v_o), PW'(m_sending));
            check("rnd_ready", PW'(io.ready_o), PW'(!m_sending));
            check("rnd_cnt", PW'(word_cnt), PW'(m_words.size()));
            check("rnd_pcnt", PW'(pkt_cnt), PW'(m_pcnt));
            check("rnd_timeout", PW'(timeout), PW'(m_tpulse));
        end

        // ---------- partial-packet timeout ----------
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 32'hE0 + k, 1'b0);
        pulses = 0;
        pulse_at = -1;
        for (int c = 1; c <= 20; c++) begin
            step(1'b0, 32'h0, 1'b0);
            if (timeout === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = c;
            end
        end
`ifdef BSG_FIFO_WORDS_TO_PKT_TIMEOUT_EN
        check("to_pulse_count", PW'(pulses), PW'(1));
        check("to_pulse_cycle", PW'(pulse_at), PW'(TO));
        check("to_word_cnt", PW'(word_cnt), PW'(0));
`else
        check("to_pulse_count", PW'(pulses), PW'(0));
        check("to_word_cnt", PW'(word_cnt), PW'(3));
`endif
        check("to_pkt_v", PW'(io.pkt_v_o), PW'(0));
        check("to_pcnt", PW'(pkt_cnt), PW'(0));

        // ---------- packet counter wrap ----------
        do_reset();
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.pkt_cnt_q;
        check("wrap_preset", PW'(pkt_cnt), PW'(32'hFFFF_FFFF));
        for (int k = 0; k < N; k++) step(1'b1, 32'hF0 + k, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        check("wrap_pcnt", PW'(pkt_cnt), PW'(0));
        check("wrap_state", PW'(state), PW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
